// File: rtl/conv_window_feeder_if.sv
// -----------------------------------------------------------------------------
// conv_window_feeder_if
//   Bundles the pixel-stream input and the 3x3 window output of the window
//   feeder into one interface.
//
//   Handshake: a beat transfers on a rising clk edge where valid && ready are
//   both high. The sender holds valid and data stable until the transfer happens.
//   ready may depend combinationally on the receiver's state.
//
//   Signals
//     s_valid   pixel source -> feeder   pixel valid
//     s_ready   feeder -> pixel source   feeder can accept a pixel
//     s_data    pixel source -> feeder   pixel, raster order
//     m_valid   feeder -> conv_block     window valid
//     m_ready   conv_block -> feeder     window accepted
//     m_window  feeder -> conv_block     packed 3x3 window
//     m_last    feeder -> conv_block     final window of the frame
//
//   Modports
//     master : the feeder, which produces the window stream
//     slave  : the environment (pixel source plus window sink)
// -----------------------------------------------------------------------------
interface conv_window_feeder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    s_valid;
    logic                    s_ready;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic [9*DATA_WIDTH-1:0] m_window;
    logic                    m_last;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_window, m_last
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_window, m_last
    );
endinterface

// File: rtl/conv_window_feeder.sv
// -----------------------------------------------------------------------------
// conv_window_feeder
//   Turns a raster-order pixel stream into one packed 3x3 window per valid
//   output position. Two line buffers hold the previous two image lines. A
//   3x3 shift register holds the last three columns of the window.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     bus        conv_window_feeder_if.master
//                (s_valid/s_ready/s_data in, m_valid/m_ready/m_window/m_last out)
//     s_sof_i    (FRAME_SYNC_EN only) start-of-frame marker for the pixel
//     sof_err_o  (FRAME_SYNC_EN only) one-cycle pulse: SOF arrived while the
//                counters were not at (0,0)
//
//   Window packing:
//     m_window[DATA_WIDTH*(3*r+c) +: DATA_WIDTH] = pixel(row-2+r, col-2+c)
//
//   Optional feature macro: FRAME_SYNC_EN (adds s_sof_i / sof_err_o).
// -----------------------------------------------------------------------------
module conv_window_feeder #(
    parameter int IMAGE_WIDTH = 14,
    parameter int IMAGE_HIGHT = 14,
    parameter int DATA_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef FRAME_SYNC_EN
    input  logic s_sof_i,
    output logic sof_err_o,
`endif
    conv_window_feeder_if.master bus
);
    localparam int OUTPUT_WIDTH = IMAGE_WIDTH - 3 + 1;
    localparam int OUTPUT_HIGHT = IMAGE_HIGHT - 3 + 1;
    localparam int COL_W        = $clog2(IMAGE_WIDTH);
    localparam int ROW_W        = $clog2(IMAGE_HIGHT);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMAGE_HIGHT - 1);
    // First column/row whose pixel completes a window (2 for a 3x3 kernel).
    localparam logic [COL_W-1:0] COL_FIRST_OUT = COL_W'(IMAGE_WIDTH - OUTPUT_WIDTH);
    localparam logic [ROW_W-1:0] ROW_FIRST_OUT = ROW_W'(IMAGE_HIGHT - OUTPUT_HIGHT);

    typedef logic [DATA_WIDTH-1:0] pix_t;

    // Line buffers and the shift window are never reset. A window is emitted
    // only after all of its nine entries have been overwritten in the current frame.
    pix_t linebuf0_q [IMAGE_WIDTH];   // row r-1
    pix_t linebuf1_q [IMAGE_WIDTH];   // row r-2
    pix_t win_q      [3][3];
    pix_t win_d      [3][3];

    logic [COL_W-1:0]        col_q, col_d, pos_col;
    logic [ROW_W-1:0]        row_q, row_d, pos_row;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [9*DATA_WIDTH-1:0] m_window_q, m_window_d, win_packed;
    logic                    sof_err_q, sof_err_d;
    logic                    s_ready, accept, emit, sof;

`ifdef FRAME_SYNC_EN
    assign sof       = s_sof_i;
    assign sof_err_o = sof_err_q;
`else
    assign sof       = 1'b0;
`endif

    // Accept a new pixel when the output slot is empty or is being drained
    // in this same cycle. This keeps full throughput at 1 pixel/cycle.
    assign s_ready      = !m_valid_q || bus.m_ready;
    assign accept       = bus.s_valid && s_ready;
    assign bus.s_ready  = s_ready;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_window = m_window_q;
    assign bus.m_last   = m_last_q;

    // Position of the pixel being accepted. A SOF pixel is forced to (0,0).
    always_comb begin
        pos_col = sof ? '0 : col_q;
        pos_row = sof ? '0 : row_q;
    end

    assign emit = accept && (pos_col >= COL_FIRST_OUT) && (pos_row >= ROW_FIRST_OUT);

    // Shift the window one column left. The new right-hand column is
    // {row-2, row-1, current} from top to bottom.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = linebuf1_q[pos_col];
        win_d[1][2] = linebuf0_q[pos_col];
        win_d[2][2] = bus.s_data;
    end

    always_comb begin
        win_packed = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_packed[DATA_WIDTH*(3*r+c) +: DATA_WIDTH] = win_d[r][c];
            end
        end
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        m_window_d = m_window_q;
        sof_err_d  = accept && sof && ((col_q != '0) || (row_q != '0));

        if (accept) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
        end

        // The accept condition already implies that the old window is gone (or
        // is leaving now). The output slot therefore takes exactly what this
        // pixel produces.
        if (accept) begin
            m_valid_d = emit;
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end

        if (emit) begin
            m_window_d = win_packed;
            m_last_d   = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
        end else if (!m_valid_d) begin
            m_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_window_q <= '0;
            sof_err_q  <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            m_window_q <= m_window_d;
            sof_err_q  <= sof_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1_q[pos_col] <= linebuf0_q[pos_col];
            linebuf0_q[pos_col] <= bus.s_data;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

`ifndef FRAME_SYNC_EN
    // The SOF error register exists only to keep the next-state logic uniform.
    // It has no output in this build.
    logic unused_sof_err;
    assign unused_sof_err = sof_err_q;
`endif
endmodule
